// File: rtl/matrix_mul_seq.sv
// Sequential matrix multiplier controller: streams row/column pairs of latched A and B to an
// external inner-product unit and assembles the returned products into C, one element per pair.
module matrix_mul_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   size,
  input  logic [199:0] mat_a,
  input  logic [199:0] mat_b,
  output logic [39:0]  lin,
  output logic [39:0]  col,
  input  logic [7:0]   n_in,
  input  logic         ovf_in,
  output logic [199:0] mat_c,
  output logic         busy,
  output logic         done,
  output logic         ovf,
  output logic         err
);

  typedef enum logic [1:0] {StIdle, StLoad, StCapt, StDone} state_e;

  state_e         state_q, state_d;
  logic [199:0]   a_q, a_d, b_q, b_d, mat_c_q, mat_c_d;
  logic [2:0]     size_q, size_d, r_q, r_d, c_q, c_d;
  logic [39:0]    lin_q, lin_d, col_q, col_d;
  logic           ovf_q, ovf_d, err_q, err_d;
  logic [2:0]     last;
  logic           size_ok;

  assign size_ok = (size != 3'd0) && (size <= 3'd5);
  assign last    = size_q - 3'd1;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    size_d  = size_q;
    r_d     = r_q;
    c_d     = c_q;
    lin_d   = lin_q;
    col_d   = col_q;
    mat_c_d = mat_c_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (size_ok) begin
            a_d     = mat_a;
            b_d     = mat_b;
            size_d  = size;
            mat_c_d = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
            r_d     = 3'd0;
            c_d     = 3'd0;
            state_d = StLoad;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        // Element 0 sits in the top byte; positions beyond N are zeroed so padding never counts.
        for (int k = 0; k < 5; k++) begin
          lin_d[39-8*k -: 8] = (k < int'(size_q)) ? a_q[40*int'(r_q) + 8*k +: 8] : 8'h00;
          col_d[39-8*k -: 8] = (k < int'(size_q)) ? b_q[40*k + 8*int'(c_q) +: 8] : 8'h00;
        end
        state_d = StCapt;
      end
      StCapt: begin
        mat_c_d[40*int'(r_q) + 8*int'(c_q) +: 8] = n_in;
        ovf_d = ovf_q | ovf_in;
        if (c_q == last) begin
          c_d = 3'd0;
          r_d = r_q + 3'd1;
        end else begin
          c_d = c_q + 3'd1;
        end
        state_d = ((r_q == last) && (c_q == last)) ? StDone : StLoad;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      size_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
      lin_q   <= '0;
      col_q   <= '0;
      mat_c_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      size_q  <= size_d;
      r_q     <= r_d;
      c_q     <= c_d;
      lin_q   <= lin_d;
      col_q   <= col_d;
      mat_c_q <= mat_c_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign lin   = lin_q;
  assign col   = col_q;
  assign mat_c = mat_c_q;
  assign ovf   = ovf_q;
  assign err   = err_q;
  assign busy  = (state_q == StLoad) || (state_q == StCapt);
  assign done  = (state_q == StDone);

endmodule

// File: tb/tb_matrix_mul_seq.sv
// Bench for matrix_mul_seq: directed runs feed a scoreboard of expected C/ovf/done-edge,
// and a monitor checks each done pulse against it. The inner-product unit is modelled inline.
module tb_matrix_mul_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   size = 3'd0;
  logic [199:0] mat_a = '0;
  logic [199:0] mat_b = '0;
  logic [39:0]  lin, col;
  logic [7:0]   n_in;
  logic         ovf_in;
  logic [199:0] mat_c;
  logic         busy, done, ovf, err;

  always #5 clk = ~clk;

  matrix_mul_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .size   (size),
    .mat_a  (mat_a),
    .mat_b  (mat_b),
    .lin    (lin),
    .col    (col),
    .n_in   (n_in),
    .ovf_in (ovf_in),
    .mat_c  (mat_c),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .err    (err)
  );

  // Inner-product unit: 8-bit wrapped sum, flag when the exact sum leaves the signed 8-bit range.
  int ip_acc;
  always_comb begin
    ip_acc = 0;
    for (int k = 0; k < 5; k++) begin
      ip_acc = ip_acc + int'($signed(lin[39-8*k -: 8])) * int'($signed(col[39-8*k -: 8]));
    end
    n_in   = ip_acc[7:0];
    ovf_in = (ip_acc > 127) || (ip_acc < -128);
  end

  typedef int m_t [25];
  typedef struct {
    logic [199:0] c;
    logic         o;
    int           edge_n;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   edge_cnt = 0;
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  function automatic logic [199:0] pack(input m_t m);
    logic [199:0] v;
    for (int i = 0; i < 25; i++) v[8*i +: 8] = m[i][7:0];
    return v;
  endfunction

  // Monitor: counts edges and checks every done pulse against the scoreboard head.
  always begin
    @(posedge clk);
    edge_cnt++;
    #1;
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", done, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        chk("mat_c", mat_c, mon_e.c);
        chk("ovf", ovf, mon_e.o);
        chk("done_edge", edge_cnt, mon_e.edge_n);
      end
    end
  end

  task automatic push_exp(input logic [199:0] c, input logic o, input int edge_n);
    exp_t e;
    e.c = c;
    e.o = o;
    e.edge_n = edge_n;
    sb.push_back(e);
  endtask

  // Issues one start; inputs are scrambled right after the accepting edge.
  task automatic issue(input logic [2:0] n, input logic [199:0] a, input logic [199:0] b,
                       input logic [199:0] c, input logic o);
    @(negedge clk);
    mat_a = a;
    mat_b = b;
    size  = n;
    start = 1'b1;
    push_exp(c, o, edge_cnt + 1 + 2 * int'(n) * int'(n));
    @(negedge clk);
    start = 1'b0;
    mat_a = ~a;
    mat_b = ~b;
    size  = 3'd1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy || done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait_pending", sb.size(), 0);
  endtask

  initial begin
    m_t ma, mb, mc;
    logic [199:0] c3;
    int e0;

    #12;
    chk("rst_mat_c", mat_c, '0);
    chk("rst_lincol", {lin, col}, '0);
    chk("rst_flags", {busy, done, ovf, err}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // N=2, A=identity with garbage outside the 2x2 region.
    ma = '{default: 0}; mb = '{default: 0}; mc = '{default: 0};
    ma[0] = 1; ma[6] = 1; ma[2] = 9; ma[24] = 7;
    mb[0] = 3; mb[1] = 4; mb[5] = 5; mb[6] = 6; mb[10] = 9;
    mc[0] = 3; mc[1] = 4; mc[5] = 5; mc[6] = 6;
    issue(3'd2, pack(ma), pack(mb), pack(mc), 1'b0);
    chk("busy_run", busy, 1'b1);
    wait_idle(100);

    // N=5, single row/column products.
    ma = '{default: 0}; mb = '{default: 0}; mc = '{default: 0};
    ma[0] = 1; ma[1] = 2; ma[2] = 3; ma[3] = 2; ma[4] = 5;
    mb[0] = 2; mb[5] = 3; mb[10] = 2; mb[15] = 1; mb[20] = 1;
    mc[0] = 21;
    issue(3'd5, pack(ma), pack(mb), pack(mc), 1'b0);
    wait_idle(200);
    ma = '{default: 0}; mb = '{default: 0}; mc = '{default: 0};
    for (int i = 0; i < 5; i++) ma[i] = -1;
    mb[0] = 2; mb[5] = 3; mb[10] = -2; mb[15] = 1; mb[20] = -2;
    mc[0] = -2;
    issue(3'd5, pack(ma), pack(mb), pack(mc), 1'b0);
    wait_idle(200);

    // N=3, all 127: each sum is 48387, wrapping to 3, with overflow.
    ma = '{default: 127}; mb = '{default: 127}; mc = '{default: 0};
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) mc[5*r+c] = 3;
    c3 = pack(mc);
    issue(3'd3, pack(ma), pack(mb), c3, 1'b1);
    wait_idle(100);
    repeat (3) @(negedge clk);
    chk("ovf_hold", ovf, 1'b1);
    chk("c_hold", mat_c, c3);

    // Illegal sizes leave C and ovf alone.
    size = 3'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("err_size0", err, 1'b1);
    chk("busy_size0", busy, 1'b0);
    chk("c_size0", mat_c, c3);
    chk("ovf_size0", ovf, 1'b1);
    size = 3'd6; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("err_size6", err, 1'b1);
    chk("busy_size6", busy, 1'b0);
    chk("c_size6", mat_c, c3);

    // N=1 run clears err and ovf.
    ma = '{default: 0}; mb = '{default: 0}; mc = '{default: 0};
    ma[0] = 5; ma[1] = 9; mb[0] = -3; mb[5] = 9;
    mc[0] = -15;
    issue(3'd1, pack(ma), pack(mb), pack(mc), 1'b0);
    chk("err_cleared", err, 1'b0);
    wait_idle(50);

    // Reset in cycle 5 of an N=3 run aborts it.
    @(negedge clk);
    mat_a = {200{1'b0}} | pack('{default: 127});
    mat_b = mat_a;
    size = 3'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mat_c", mat_c, '0);
    chk("rst_mid_lincol", {lin, col}, '0);
    chk("rst_mid_flags", {busy, done, ovf, err}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    ma = '{default: 0}; mb = '{default: 0}; mc = '{default: 0};
    ma[0] = 2; ma[6] = 2; ma[12] = 2;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) begin
      mb[5*r+c] = 3 * r + c + 1;
      mc[5*r+c] = 2 * (3 * r + c + 1);
    end
    issue(3'd3, pack(ma), pack(mb), pack(mc), 1'b0);
    wait_idle(100);

    // Start held through an N=2 run with A changed mid-run; a second run follows from IDLE.
    ma = '{default: 0}; mb = '{default: 0}; mc = '{default: 0};
    mb[0] = 1; mb[6] = 1;
    ma[0] = 1; ma[1] = 2; ma[5] = 3; ma[6] = 4;
    @(negedge clk);
    mat_a = pack(ma); mat_b = pack(mb); size = 3'd2; start = 1'b1;
    e0 = edge_cnt + 1;
    push_exp(pack(ma), 1'b0, e0 + 8);
    ma[0] = 5; ma[1] = 6; ma[5] = 7; ma[6] = 8;
    push_exp(pack(ma), 1'b0, e0 + 18);
    repeat (4) @(negedge clk);
    mat_a = pack(ma);
    while (edge_cnt < e0 + 10) @(negedge clk);
    start = 1'b0;
    chk("busy_rerun", busy, 1'b1);
    wait_idle(100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/matrix_mul_seq.md
MATRIX_MUL_SEQ -- requirements
Module: matrix_mul_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  in  1  system clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  asynchronous active-low reset.
REQ-004 Port: start  in  1  request to begin a multiply; sampled only in IDLE.
REQ-005 Port: size  in  3  matrix dimension N (unsigned); legal range is 1..5.
REQ-006 Port: mat_a  in  200  matrix A, 25 signed 8-bit values, row-major; element (r,c) at bits [8*(5r+c)+7 : 8*(5r+c)].
REQ-007 Port: mat_b  in  200  matrix B, same packing as mat_a.
REQ-008 Port: lin  out  40  row r of A to the inner-product unit; element k at bits [39-8k : 32-8k].
REQ-009 Port: col  out  40  column c of B, same packing as lin.
REQ-010 Port: n_in  in  8  signed inner product returned by the inner-product unit.
REQ-011 Port: ovf_in  in  1  overflow flag from the inner-product unit.
REQ-012 Port: mat_c  out  200  result matrix C, same packing as mat_a.
REQ-013 Port: busy  out  1  high while a multiply is in progress.
REQ-014 Port: done  out  1  one-cycle completion pulse.
REQ-015 Port: ovf  out  1  sticky OR of ovf_in over the current run.
REQ-016 Port: err  out  1  high when the last start request carried an illegal size.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, LOAD, CAPT and DONE; busy=1 in LOAD/CAPT only; done=1 in DONE only.
REQ-018 IDLE with start=1 and size in 1..5 SHALL cause the following at the edge: latch mat_a, mat_b and size internally; clear mat_c, ovf and err; set r=c=0; go to LOAD.
REQ-019 IDLE with start=1 and size of 0 or 6..7 SHALL set err=1, stay in IDLE, and leave mat_c and ovf unchanged.
REQ-020 LOAD SHALL register lin and col with row r of A and column c of B, zero element positions k>=N, and go to CAPT.
REQ-021 CAPT SHALL perform the following at the edge: write n_in into C(r,c); OR ovf_in into ovf; advance c, and on c=N-1 wrap c to 0 and increment r.
REQ-022 CAPT SHALL then go to DONE if (r,c)=(N-1,N-1) before the advance, otherwise to LOAD.
REQ-023 DONE SHALL return to IDLE on the next edge.
REQ-024 Latency: with the accepting edge numbered E0, the last capture SHALL occur at edge E(2*N*N), and done SHALL be high for exactly the one cycle that follows it.
REQ-025 C elements outside the NxN region SHALL read 0.
REQ-026 mat_c and ovf SHALL hold their values after DONE until the next accepted start or reset.
REQ-027 start SHALL be ignored in LOAD, CAPT and DONE.
REQ-028 Changes on mat_a, mat_b or size after the accepting edge SHALL have no effect on the run in progress.
REQ-029 n_in SHALL be stored without modification; this block performs no arithmetic on products.

Reset
REQ-030 rst_n=0 SHALL force the following immediately, regardless of clk: state IDLE; r=c=0; lin, col and mat_c all 0; busy, done, ovf and err all 0.
REQ-031 Reset asserted mid-run SHALL abort the run with no done pulse; the first start after rst_n returns high SHALL be accepted normally.

Verification
REQ-032 The bench SHALL connect lin, col, n_in and ovf_in to the team's inner-product unit (intProd_M).
REQ-033 Scenario: N=2, A=identity, B=[[3,4],[5,6]] -> mat_c holds 3,4,5,6 in the 2x2 region and 0 elsewhere; done at cycle after E8; ovf=0.
REQ-034 Scenario: N=5, A row0=1,2,3,2,5 and B col0=2,3,2,1,1 -> C(0,0)=21; a second run with A row0 all -1 and B col0=2,3,-2,1,-2 -> C(0,0)=-2.
REQ-035 Scenario: N=3, A and B all 127 -> ovf=1 at done and held until the next start; the next non-overflowing run -> ovf=0.
REQ-036 Scenario: start with size=0, then with size=6 -> err=1, busy stays 0, mat_c unchanged; then start with size=1 -> err=0 and done at cycle after E2.
REQ-037 Scenario: rst_n pulsed low at cycle 5 of an N=3 run -> all outputs 0 immediately and no done; a restart completes in 18 edges.
REQ-038 Scenario: start held high for the whole N=2 run, with mat_a toggled mid-run -> exactly one done at cycle after E8, results from the latched A, then a new run accepted in IDLE.
